instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue_pkg.sv | 25 ++
 rtl/instruction_queue_window.sv | 21 ++
 rtl/instruction_queue.sv | 134 +++++++++++++
 tb/tb_instruction_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared constants and types for the instruction byte queue.
// Optional INSTRUCTION_QUEUE_PERF_EN adds flush/starve counters in the top.
package instruction_queue_pkg;

  localparam int QUEUE_DEPTH  = 32;
  localparam int WINDOW_BYTES = 16;
  localparam int FILL_BYTES   = 4;

  localparam int PTR_W  = 5;
  localparam int CNT_W  = 6;
  localparam int LEN_W  = 5;
  localparam int FCNT_W = 3;
  localparam int PERF_W = 16;

  typedef logic [7:0] byte_t;
  typedef logic [QUEUE_DEPTH-1:0][7:0] qbuf_t;
  typedef logic [0:WINDOW_BYTES-1][7:0] window_t;

  function automatic logic [PERF_W-1:0] sat_inc(
    input logic [PERF_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instruction_queue_window.sv
// Head-relative rotate-and-mask of the byte buffer into a 16-byte window.
// Ports: buffer, head, count in; window out (index 0 = oldest byte).
module instruction_queue_window
  import instruction_queue_pkg::*;
(
  input  qbuf_t              buffer,
  input  logic [PTR_W-1:0]   head,
  input  logic [CNT_W-1:0]   count,
  output window_t            window
);

  // Index arithmetic is 5 bits wide, so entry 31 -> 0 wraps for free.
  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (CNT_W'(i) < count)
        window[i] = buffer[head + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/instruction_queue.sv
// 32-byte circular code-byte queue between fetch fill and decode consume.
// Ports: clock/reset/flush, fill_*, consume_*, instruction window,
// bytes_available, consume_error; INSTRUCTION_QUEUE_PERF_EN adds
// flush_count and starve_count.
module instruction_queue
  import instruction_queue_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [31:0]         fill_data,
  input  logic [FCNT_W-1:0]   fill_count,
  output window_t             instruction,
  output logic [CNT_W-1:0]    bytes_available,
  input  logic                consume_valid,
  input  logic [LEN_W-1:0]    consume_length,
  output logic                consume_error
`ifdef INSTRUCTION_QUEUE_PERF_EN
  ,
  output logic [PERF_W-1:0]   flush_count,
  output logic [PERF_W-1:0]   starve_count
`endif
);

  qbuf_t             mem_q;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cerr_q, cerr_d;

  logic              fill_ok;
  logic              cons_ok;
  logic              wr_en;
  logic [CNT_W-1:0]  fill_amt;
  logic [CNT_W-1:0]  cons_amt;
  logic [CNT_W-1:0]  len_ext;

  assign len_ext    = {1'b0, consume_length};
  assign fill_ready = count_q <= CNT_W'(QUEUE_DEPTH - FILL_BYTES);

  // Consume is judged against the pre-fill count.
  always_comb begin
    fill_ok = fill_valid & fill_ready & ~flush
            & (fill_count != '0)
            & (fill_count <= FCNT_W'(FILL_BYTES));
    cons_ok = consume_valid & ~flush
            & (consume_length != '0)
            & (len_ext <= count_q);
  end

  assign wr_en    = fill_ok & ~reset;
  assign fill_amt = fill_ok ? CNT_W'(fill_count) : '0;
  assign cons_amt = cons_ok ? len_ext : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cerr_d  = consume_valid & ~flush & ~cons_ok;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(cons_amt);
      tail_d  = tail_q + PTR_W'(fill_amt);
      count_d = count_q + fill_amt - cons_amt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cerr_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cerr_q  <= cerr_d;
    end
  end

  // Storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int j = 0; j < FILL_BYTES; j++) begin
        if (FCNT_W'(j) < fill_count)
          mem_q[tail_q + PTR_W'(j)] <= fill_data[8*j +: 8];
      end
    end
  end

  instruction_queue_window u_window (
    .buffer (mem_q),
    .head   (head_q),
    .count  (count_q),
    .window (instruction)
  );

  assign bytes_available = count_q;
  assign consume_error   = cerr_q;

`ifdef INSTRUCTION_QUEUE_PERF_EN
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (flush)
      flush_cnt_d = sat_inc(flush_cnt_q);
    if (consume_valid && (count_q < len_ext))
      starve_cnt_d = sat_inc(starve_cnt_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign flush_count  = flush_cnt_q;
  assign starve_count = starve_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: a byte-queue model predicts
// each cycle's outputs, checked #1 after the clock edge.
module tb_instruction_queue;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              fill_valid;
  logic              fill_ready;
  logic [31:0]       fill_data;
  logic [2:0]        fill_count;
  logic [0:15][7:0]  instruction;
  logic [5:0]        bytes_available;
  logic              consume_valid;
  logic [4:0]        consume_length;
  logic              consume_error;
`ifdef INSTRUCTION_QUEUE_PERF_EN
  logic [15:0]       flush_count;
  logic [15:0]       starve_count;
`endif

  always #5 clock = ~clock;

  instruction_queue dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .fill_valid      (fill_valid),
    .fill_ready      (fill_ready),
    .fill_data       (fill_data),
    .fill_count      (fill_count),
    .instruction     (instruction),
    .bytes_available (bytes_available),
    .consume_valid   (consume_valid),
    .consume_length  (consume_length),
    .consume_error   (consume_error)
`ifdef INSTRUCTION_QUEUE_PERF_EN
    ,
    .flush_count     (flush_count),
    .starve_count    (starve_count)
`endif
  );

  typedef struct {
    int unsigned      cnt;
    logic [0:15][7:0] win;
    logic             rdy;
    logic             err;
    int unsigned      fcnt;
    int unsigned      scnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  int unsigned m_fcnt;
  int unsigned m_scnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic fl,
                      input logic fv, input logic [31:0] fd,
                      input logic [2:0] fc,
                      input logic cv, input logic [4:0] cl);
    exp_t e;
    int   pre;
    bit   f_acc, c_acc;
    reset          = rs;
    flush          = fl;
    fill_valid     = fv;
    fill_data      = fd;
    fill_count     = fc;
    consume_valid  = cv;
    consume_length = cl;
    pre   = mq.size();
    f_acc = fv && (pre <= 28) && !fl && fc >= 1 && fc <= 4;
    c_acc = cv && !fl && cl >= 1 && int'(cl) <= pre;
    e.err = cv && !fl && !c_acc;
    if (fl && m_fcnt < 65535) m_fcnt++;
    if (cv && pre < int'(cl) && m_scnt < 65535) m_scnt++;
    if (rs) begin
      mq.delete();
      e.err  = 1'b0;
      m_fcnt = 0;
      m_scnt = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (c_acc)
        for (int k = 0; k < int'(cl); k++) void'(mq.pop_front());
      if (f_acc)
        for (int k = 0; k < int'(fc); k++) mq.push_back(fd[8*k +: 8]);
    end
    e.cnt = mq.size();
    e.rdy = (e.cnt <= 28);
    e.win = '0;
    for (int k = 0; k < 16; k++)
      if (k < mq.size()) e.win[k] = mq[k];
    e.fcnt = m_fcnt;
    e.scnt = m_scnt;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("bytes_available", 128'(bytes_available), 128'(e.cnt));
    check("instruction", instruction, e.win);
    check("fill_ready", 128'(fill_ready), 128'(e.rdy));
    check("consume_error", 128'(consume_error), 128'(e.err));
`ifdef INSTRUCTION_QUEUE_PERF_EN
    check("flush_count", 128'(flush_count), 128'(e.fcnt));
    check("starve_count", 128'(starve_count), 128'(e.scnt));
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 3'd0, 0, 5'd0);
  endtask

  task automatic fill(input logic [31:0] d, input logic [2:0] c);
    step(0, 0, 1, d, c, 0, 5'd0);
  endtask

  task automatic consume(input logic [4:0] l);
    step(0, 0, 0, 32'h0, 3'd0, 1, l);
  endtask

  initial begin
    logic [31:0] d;
    m_fcnt = 0;
    m_scnt = 0;
    // Reset with competing activity; reset must win.
    step(1, 1, 1, 32'hDEADBEEF, 3'd4, 1, 5'd1);
    step(1, 0, 0, 32'h0, 3'd0, 0, 5'd0);
    // Four fills of 00..0F.
    for (int i = 0; i < 4; i++) begin
      d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      fill(d, 3'd4);
    end
    check("win_byte15", 128'(instruction[15]), 128'(8'h0F));
    // Illegal fill counts are ignored.
    fill(32'hAAAAAAAA, 3'd0);
    fill(32'hBBBBBBBB, 3'd5);
    // Fill to full.
    for (int i = 4; i < 8; i++) begin
      d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      fill(d, 3'd4);
    end
    check("full_ready", 128'(fill_ready), 128'(1'b0));
    fill(32'hCCCCCCCC, 3'd4);
    consume(5'd4);
    check("after_cons_cnt", 128'(bytes_available), 128'(6'd28));
    // Walk head to 30 and wrap the tail.
    consume(5'd16);
    consume(5'd10);
    fill(32'h33221100 ^ 32'h11111111, 3'd4);
    check("wrap_win0", 128'(instruction[0]), 128'(8'h1E));
    // Reach 10 bytes, then simultaneous fill 4 + consume 3.
    fill(32'h77665544, 3'd4);
    step(0, 0, 1, 32'h9988AA55, 3'd4, 1, 5'd3);
    check("sim_cnt", 128'(bytes_available), 128'(6'd11));
    // Down to 2 bytes, then a starving consume.
    consume(5'd9);
    consume(5'd5);
    idle();
    consume(5'd0);
    // Build to 20 and flush with concurrent traffic.
    for (int i = 0; i < 5; i++) fill(32'h0F0E0D0C + 32'(i), 3'd4);
    consume(5'd2);
    step(0, 1, 1, 32'h12345678, 3'd4, 1, 5'd3);
    idle();
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 19) == 0),
           $urandom_range(0, 1), $urandom,
           3'($urandom_range(0, 5)),
           $urandom_range(0, 1), 5'($urandom_range(0, 18)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
